// File: rtl/scan_chain_ctrl_if.sv
`default_nettype none
// ============================================================================
// Interface : scan_chain_ctrl_if
// Summary   : Pattern/response handshakes and scan-chain pins of scan_chain_ctrl.
//             SIG exists only when SCAN_CHAIN_CTRL_MISR_EN is defined.
// Revision  : 1.0
// ============================================================================
interface scan_chain_ctrl_if #(
    parameter int CHAIN_LEN = 8
);
    logic                 PAT_VALID;
    logic                 PAT_READY;
    logic [CHAIN_LEN-1:0] PAT;
    logic                 SCAN_SO;
    logic                 SCAN_SE;
    logic                 SCAN_SI;
    logic                 SCAN_CKEN;
    logic                 RSP_VALID;
    logic                 RSP_READY;
    logic [CHAIN_LEN-1:0] RSP;
    logic                 BUSY;
`ifdef SCAN_CHAIN_CTRL_MISR_EN
    logic [15:0]          SIG;

    modport master (
        output PAT_VALID, PAT, SCAN_SO, RSP_READY,
        input  PAT_READY, SCAN_SE, SCAN_SI, SCAN_CKEN, RSP_VALID, RSP, BUSY, SIG
    );

    modport slave (
        input  PAT_VALID, PAT, SCAN_SO, RSP_READY,
        output PAT_READY, SCAN_SE, SCAN_SI, SCAN_CKEN, RSP_VALID, RSP, BUSY, SIG
    );
`else
    modport master (
        output PAT_VALID, PAT, SCAN_SO, RSP_READY,
        input  PAT_READY, SCAN_SE, SCAN_SI, SCAN_CKEN, RSP_VALID, RSP, BUSY
    );

    modport slave (
        input  PAT_VALID, PAT, SCAN_SO, RSP_READY,
        output PAT_READY, SCAN_SE, SCAN_SI, SCAN_CKEN, RSP_VALID, RSP, BUSY
    );
`endif
endinterface
`default_nettype wire

// File: rtl/scan_chain_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : scan_chain_ctrl
// Summary  : Scan sequencer (shift-in, capture, overlapped shift-out) with
//            parallel pattern/response handshakes; optional 16-bit MISR
//            signature when SCAN_CHAIN_CTRL_MISR_EN is defined.
// Revision : 1.0
// ============================================================================
module scan_chain_ctrl #(
    parameter int CHAIN_LEN   = 8,
    parameter int CAPTURE_CYC = 1
) (
    input  wire              CK,
    input  wire              RST,
    scan_chain_ctrl_if.slave bus
);

    localparam int CNT_W = $clog2(CHAIN_LEN);
    localparam int CAP_W = (CAPTURE_CYC > 1) ? $clog2(CAPTURE_CYC) : 1;

    localparam logic [1:0] c_IDLE    = 2'd0;
    localparam logic [1:0] c_SHIFT   = 2'd1;
    localparam logic [1:0] c_CAPTURE = 2'd2;
    localparam logic [1:0] c_WAIT    = 2'd3;

    localparam logic [CNT_W-1:0] c_LAST_SHIFT = CNT_W'(CHAIN_LEN - 1);
    localparam logic [CAP_W-1:0] c_LAST_CAP   = CAP_W'(CAPTURE_CYC - 1);

    logic [1:0]           r_state;
    logic [1:0]           w_state_nxt;
    logic [CNT_W-1:0]     r_shift_cnt;
    logic [CAP_W-1:0]     r_cap_cnt;
    logic                 r_load_f;
    logic                 r_unl_f;
    logic [CHAIN_LEN-1:0] r_pat_sh;
    logic [CHAIN_LEN-2:0] r_rsp_sh;
    logic [CHAIN_LEN-1:0] r_rsp;
    logic                 r_rsp_valid;

    logic                 w_pat_ready;
    logic                 w_se;
    logic                 w_si;
    logic                 w_cken;
    logic                 w_last_shift;
    logic                 w_last_cap;
    logic                 w_accept;
    logic                 w_rsp_done;
    logic [CHAIN_LEN-1:0] w_rsp_nxt;

    assign w_last_shift = (r_shift_cnt == c_LAST_SHIFT);
    assign w_last_cap   = (r_cap_cnt == c_LAST_CAP);
    assign w_accept     = w_pat_ready & bus.PAT_VALID;
    assign w_rsp_done   = (r_state == c_SHIFT) & w_last_shift & r_unl_f;
    // SCAN_SO is still the pre-edge Q of the last flop, so it completes the word.
    assign w_rsp_nxt    = {r_rsp_sh, bus.SCAN_SO};

    always_ff @(posedge CK) begin
        if (RST) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pat_ready = 1'b0;
        w_se        = 1'b0;
        w_si        = 1'b0;
        w_cken      = 1'b0;
        case (r_state)
            c_IDLE: begin
                w_pat_ready = 1'b1;
                if (bus.PAT_VALID) begin
                    w_state_nxt = c_SHIFT;
                end
            end
            c_SHIFT: begin
                w_se   = 1'b1;
                w_cken = 1'b1;
                w_si   = r_load_f & r_pat_sh[CHAIN_LEN-1];
                if (w_last_shift) begin
                    w_state_nxt = r_load_f ? c_CAPTURE : c_IDLE;
                end
            end
            c_CAPTURE: begin
                w_cken = 1'b1;
                if (w_last_cap) begin
                    w_state_nxt = c_WAIT;
                end
            end
            c_WAIT: begin
                // The captured state may only be unloaded once the previous response is gone.
                w_pat_ready = ~r_rsp_valid;
                if (!r_rsp_valid) begin
                    w_state_nxt = c_SHIFT;
                end
            end
            default: begin
                w_state_nxt = c_IDLE;
            end
        endcase
    end

    always_ff @(posedge CK) begin
        if (RST) begin
            r_shift_cnt <= '0;
            r_cap_cnt   <= '0;
            r_load_f    <= 1'b0;
            r_unl_f     <= 1'b0;
            r_pat_sh    <= '0;
            r_rsp_sh    <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_accept) begin
                        r_pat_sh    <= bus.PAT;
                        r_load_f    <= 1'b1;
                        r_unl_f     <= 1'b0;
                        r_shift_cnt <= '0;
                    end
                end
                c_SHIFT: begin
                    r_pat_sh    <= {r_pat_sh[CHAIN_LEN-2:0], 1'b0};
                    r_shift_cnt <= w_last_shift ? '0 : r_shift_cnt + 1'b1;
                    if (r_unl_f) begin
                        r_rsp_sh <= w_rsp_nxt[CHAIN_LEN-2:0];
                    end
                end
                c_CAPTURE: begin
                    r_cap_cnt <= w_last_cap ? '0 : r_cap_cnt + 1'b1;
                end
                c_WAIT: begin
                    if (!r_rsp_valid) begin
                        r_unl_f     <= 1'b1;
                        r_load_f    <= bus.PAT_VALID;
                        r_pat_sh    <= bus.PAT_VALID ? bus.PAT : '0;
                        r_shift_cnt <= '0;
                    end
                end
                default: begin
                    r_shift_cnt <= '0;
                end
            endcase
        end
    end

    // A completing unload takes priority over retiring the old response.
    always_ff @(posedge CK) begin
        if (RST) begin
            r_rsp       <= '0;
            r_rsp_valid <= 1'b0;
        end else if (w_rsp_done) begin
            r_rsp       <= w_rsp_nxt;
            r_rsp_valid <= 1'b1;
        end else if (r_rsp_valid && bus.RSP_READY) begin
            r_rsp_valid <= 1'b0;
        end
    end

`ifdef SCAN_CHAIN_CTRL_MISR_EN
    logic [15:0] r_sig;
    logic        w_fb;

    assign w_fb = r_sig[15] ^ bus.SCAN_SO;

    always_ff @(posedge CK) begin
        if (RST) begin
            r_sig <= 16'h0000;
        end else if ((r_state == c_SHIFT) && r_unl_f) begin
            r_sig <= {r_sig[14:0], 1'b0} ^ (w_fb ? 16'h1021 : 16'h0000);
        end
    end

    assign bus.SIG = r_sig;
`endif

    assign bus.PAT_READY = w_pat_ready;
    assign bus.SCAN_SE   = w_se;
    assign bus.SCAN_SI   = w_si;
    assign bus.SCAN_CKEN = w_cken;
    assign bus.RSP_VALID = r_rsp_valid;
    assign bus.RSP       = r_rsp;
    assign bus.BUSY      = (r_state != c_IDLE);

endmodule
`default_nettype wire
